// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the shrv32 RAM arbiter: access sizes, FSM
// states, grant owners and the byte-lane enable decoder.
package shrv32_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Everything the response cycle needs to know about the accepted access.
  typedef struct packed {
    owner_e     owner;
    logic       err;
    logic       wen;
    logic       uns;
    logic [1:0] size;
    logic [1:0] off;
  } pend_t;

  function automatic logic [3:0] byteena_f(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'hF;
      default: be = 4'h0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_arbiter_load_align.sv
// Load-data aligner: moves the addressed lane(s) of the RAM word down to bit 0
// and sign- or zero-extends them to 32 bits.
module mem_load_align
  import shrv32_mem_pkg::*;
(
  input  logic [31:0] ram_q_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  assign shifted = ram_q_i >> {off_i, 3'b000};

  always_comb begin
    data_o = 32'h0;
    case (size_i)
      SZ_B:    data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      SZ_W:    data_o = shifted;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between fetch and load/store, one access per two
// cycles. Define MEM_ARBITER_RR_EN for round-robin ties; otherwise data wins.
module mem_arbiter
  import shrv32_mem_pkg::*;
#(
  parameter int RAM_AW = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic        d_wen,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] ram_address,
  output logic [3:0]  ram_byteena,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  state_e state_q, state_d;
  pend_t  pend_q, pend_d;

  logic i_err, d_err;
  assign i_err = (|i_addr[31:RAM_AW+2]) | (|i_addr[1:0]);
  assign d_err = (|d_addr[31:RAM_AW+2]) | (d_size == 2'd3)
               | ((d_size == SZ_H) & d_addr[0])
               | ((d_size == SZ_W) & (|d_addr[1:0]));

  logic tie_dat;
`ifdef MEM_ARBITER_RR_EN
  owner_e last_q;
  assign tie_dat = (last_q == OWN_I);
`else
  assign tie_dat = 1'b1;
`endif

  logic gnt_dat, gnt_ins;
  assign gnt_dat = (state_q == ST_IDLE) & d_valid & (~i_valid | tie_dat);
  assign gnt_ins = (state_q == ST_IDLE) & i_valid & ~gnt_dat;
  assign d_ready = gnt_dat;
  assign i_ready = gnt_ins;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    ram_address = 32'h0;
    ram_byteena = 4'h0;
    ram_data    = 32'h0;
    ram_wren    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_dat) begin
          state_d     = ST_BUSY;
          pend_d      = '{owner: OWN_D, err: d_err, wen: d_wen, uns: d_unsigned,
                          size: d_size, off: d_addr[1:0]};
          ram_address = {{(32-RAM_AW){1'b0}}, d_addr[RAM_AW+1:2]};
          if (!d_err) begin
            ram_byteena = byteena_f(d_size, d_addr[1:0]);
            ram_data    = d_wdata << {d_addr[1:0], 3'b000};
            ram_wren    = d_wen;
          end
        end else if (gnt_ins) begin
          state_d     = ST_BUSY;
          pend_d      = '{owner: OWN_I, err: i_err, wen: 1'b0, uns: 1'b0,
                          size: SZ_W, off: 2'd0};
          ram_address = {{(32-RAM_AW){1'b0}}, i_addr[RAM_AW+1:2]};
          ram_byteena = i_err ? 4'h0 : 4'hF;
        end
      end
      ST_BUSY: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= OWN_I;
    end else if (gnt_dat) begin
      last_q <= OWN_D;
    end else if (gnt_ins) begin
      last_q <= OWN_I;
    end
  end
`endif

  logic [31:0] load_data;
  mem_load_align u_align (
    .ram_q_i    (ram_q),
    .off_i      (pend_q.off),
    .size_i     (pend_q.size),
    .unsigned_i (pend_q.uns),
    .data_o     (load_data)
  );

  // Response data is only exposed during the pulse, and forced to 0 for errors and stores.
  logic busy;
  assign busy        = (state_q == ST_BUSY);
  assign i_rsp_valid = busy & (pend_q.owner == OWN_I);
  assign d_rsp_valid = busy & (pend_q.owner == OWN_D);
  assign i_rsp_err   = i_rsp_valid & pend_q.err;
  assign d_rsp_err   = d_rsp_valid & pend_q.err;
  assign i_rsp_data  = (i_rsp_valid & ~pend_q.err) ? ram_q : 32'h0;
  assign d_rsp_data  = (d_rsp_valid & ~pend_q.err & ~pend_q.wen) ? load_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-level reference model plus
// directed accesses with hand-computed results.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int RAM_BYTES = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid, i_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_addr, i_rsp_data;
  logic        d_valid, d_ready, d_wen, d_unsigned, d_rsp_valid, d_rsp_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic [31:0] ram_address, ram_data, ram_q;
  logic [3:0]  ram_byteena;
  logic        ram_wren;

  always #5 clock = ~clock;

  mem_arbiter #(.RAM_AW(8)) dut (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .ram_address(ram_address), .ram_byteena(ram_byteena), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // RAM attached to the port: registered read, disabled lanes read as 0.
  logic [31:0] mem [256];
  logic [31:0] q_reg = 32'h0;
  assign ram_q = q_reg;
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (ram_wren && ram_byteena[b]) mem[ram_address[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
    q_reg <= mem[ram_address[7:0]] & {{8{ram_byteena[3]}}, {8{ram_byteena[2]}},
                                      {8{ram_byteena[1]}}, {8{ram_byteena[0]}}};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory and a pending-response record.
  logic [7:0]  ref_mem [RAM_BYTES];
  logic        m_busy = 1'b0;
  logic        m_own_d = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic        m_last_d = 1'b0;

  always @(negedge clock) begin
    logic gd, gi, err;
    int   n;
    logic [31:0] v;
    if (reset) begin
      chk("rst_i_ready", {31'h0, i_ready}, 32'h0);
      chk("rst_d_ready", {31'h0, d_ready}, 32'h0);
      chk("rst_rsp_valid", {30'h0, i_rsp_valid, d_rsp_valid}, 32'h0);
      chk("rst_rsp_err", {30'h0, i_rsp_err, d_rsp_err}, 32'h0);
      chk("rst_i_rsp_data", i_rsp_data, 32'h0);
      chk("rst_d_rsp_data", d_rsp_data, 32'h0);
      chk("rst_ram_strobe", {27'h0, ram_wren, ram_byteena}, 32'h0);
      chk("rst_ram_address", ram_address, 32'h0);
      m_busy   = 1'b0;
      m_last_d = 1'b0;
    end else if (m_busy) begin
      chk("busy_ready", {30'h0, i_ready, d_ready}, 32'h0);
      chk("busy_ram", {27'h0, ram_wren, ram_byteena}, 32'h0);
      chk("busy_ram_address", ram_address, 32'h0);
      chk("busy_ram_data", ram_data, 32'h0);
      chk("i_rsp_valid", {31'h0, i_rsp_valid}, {31'h0, !m_own_d});
      chk("d_rsp_valid", {31'h0, d_rsp_valid}, {31'h0, m_own_d});
      if (m_own_d) begin
        chk("d_rsp_data", d_rsp_data, m_data);
        chk("d_rsp_err", {31'h0, d_rsp_err}, {31'h0, m_err});
      end else begin
        chk("i_rsp_data", i_rsp_data, m_data);
        chk("i_rsp_err", {31'h0, i_rsp_err}, {31'h0, m_err});
      end
      m_busy = 1'b0;
    end else begin
      chk("idle_rsp_valid", {30'h0, i_rsp_valid, d_rsp_valid}, 32'h0);
`ifdef MEM_ARBITER_RR_EN
      gd = d_valid && (!i_valid || !m_last_d);
`else
      gd = d_valid;
`endif
      gi = i_valid && !gd;
      chk("i_ready", {31'h0, i_ready}, {31'h0, gi});
      chk("d_ready", {31'h0, d_ready}, {31'h0, gd});
      if (!gd && !gi) begin
        chk("nogrant_ram", {27'h0, ram_wren, ram_byteena}, 32'h0);
        chk("nogrant_address", ram_address, 32'h0);
        chk("nogrant_data", ram_data, 32'h0);
      end else if (gi) begin
        err = (i_addr % 4 != 0) || (i_addr >= RAM_BYTES);
        chk("fetch_wren", {31'h0, ram_wren}, 32'h0);
        chk("fetch_be", {28'h0, ram_byteena}, err ? 32'h0 : 32'hF);
        if (!err) chk("fetch_address", ram_address, i_addr / 4);
        m_own_d = 1'b0;
        m_err   = err;
        m_data  = err ? 32'h0 : {ref_mem[i_addr+3], ref_mem[i_addr+2],
                                 ref_mem[i_addr+1], ref_mem[i_addr]};
      end else begin
        n   = (d_size == 2'd0) ? 1 : (d_size == 2'd1) ? 2 : (d_size == 2'd2) ? 4 : 0;
        err = (n == 0) || (d_addr >= RAM_BYTES) || (d_addr % n != 0);
        m_data = 32'h0;
        if (err) begin
          chk("derr_strobe", {27'h0, ram_wren, ram_byteena}, 32'h0);
        end else begin
          chk("d_be", {28'h0, ram_byteena}, ((32'h1 << n) - 1) << (d_addr % 4));
          chk("d_address", ram_address, d_addr / 4);
          chk("d_ram_data", ram_data, d_wdata << (8 * (d_addr % 4)));
          chk("d_wren", {31'h0, ram_wren}, {31'h0, d_wen});
          if (d_wen) begin
            for (int b = 0; b < n; b++) ref_mem[d_addr + b] = d_wdata[8*b +: 8];
          end else begin
            v = 32'h0;
            for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[d_addr + b];
            if (!d_unsigned && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
            m_data = v;
          end
        end
        m_own_d = 1'b1;
        m_err   = err;
      end
      if (gd || gi) begin
        m_busy   = 1'b1;
        m_last_d = gd;
      end
    end
  end

  task automatic d_req(input logic [31:0] a, input logic wen, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd,
                       output logic [31:0] r_data, output logic r_err, output logic [3:0] r_be,
                       output logic [31:0] r_addr, output logic [31:0] r_wdat, output logic r_wren);
    int k;
    @(posedge clock); #1;
    d_addr = a; d_wen = wen; d_size = sz; d_unsigned = uns; d_wdata = wd; d_valid = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!d_ready && k < 10);
    chk("d_accept", {31'h0, d_ready}, 32'h1);
    r_be = ram_byteena; r_addr = ram_address; r_wdat = ram_data; r_wren = ram_wren;
    @(posedge clock); #1;
    d_valid = 1'b0;
    @(negedge clock);
    chk("d_rsp_pulse", {31'h0, d_rsp_valid}, 32'h1);
    r_data = d_rsp_data; r_err = d_rsp_err;
    $display("d access addr=%h wen=%0d size=%0d uns=%0d -> data=%h err=%0d", a, wen, sz, uns, r_data, r_err);
  endtask

  task automatic i_req(input logic [31:0] a, output logic [31:0] r_data, output logic r_err);
    int k;
    @(posedge clock); #1;
    i_addr = a; i_valid = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!i_ready && k < 10);
    chk("i_accept", {31'h0, i_ready}, 32'h1);
    @(posedge clock); #1;
    i_valid = 1'b0;
    @(negedge clock);
    chk("i_rsp_pulse", {31'h0, i_rsp_valid}, 32'h1);
    r_data = i_rsp_data; r_err = i_rsp_err;
    $display("fetch addr=%h -> data=%h err=%0d", a, r_data, r_err);
  endtask

  initial begin
    logic [31:0] rd, ra, rw;
    logic        re, rwr;
    logic [3:0]  rb, ord;
    int          k, g;

    for (int w = 0; w < 256; w++) mem[w] = 32'h0;
    for (int b = 0; b < RAM_BYTES; b++) ref_mem[b] = 8'h0;
    mem[4] = 32'hDEADBEEF;
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;
    i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_wen = 0; d_size = 0;
    d_unsigned = 0; d_wdata = 0;

    repeat (3) @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;

    i_req(32'h10, rd, re);
    chk("lit_fetch_data", rd, 32'hDEADBEEF);
    chk("lit_fetch_err", {31'h0, re}, 32'h0);

    d_req(32'h23, 1'b1, 2'd0, 1'b0, 32'h000000A5, rd, re, rb, ra, rw, rwr);
    chk("lit_sb_address", ra, 32'd8);
    chk("lit_sb_be", {28'h0, rb}, 32'h8);
    chk("lit_sb_data", rw, 32'hA5000000);
    chk("lit_sb_wren", {31'h0, rwr}, 32'h1);
    chk("lit_sb_rsp", rd, 32'h0);

    d_req(32'h23, 1'b0, 2'd0, 1'b0, 32'h0, rd, re, rb, ra, rw, rwr);
    chk("lit_lb", rd, 32'hFFFFFFA5);
    d_req(32'h23, 1'b0, 2'd0, 1'b1, 32'h0, rd, re, rb, ra, rw, rwr);
    chk("lit_lbu", rd, 32'h000000A5);

    d_req(32'h22, 1'b1, 2'd1, 1'b0, 32'h0000BEEF, rd, re, rb, ra, rw, rwr);
    chk("lit_sh_be", {28'h0, rb}, 32'hC);
    d_req(32'h22, 1'b0, 2'd1, 1'b0, 32'h0, rd, re, rb, ra, rw, rwr);
    chk("lit_lh", rd, 32'hFFFFBEEF);

    d_req(32'h21, 1'b0, 2'd1, 1'b0, 32'h0, rd, re, rb, ra, rw, rwr);
    chk("lit_lh_mis_err", {31'h0, re}, 32'h1);
    chk("lit_lh_mis_data", rd, 32'h0);
    chk("lit_lh_mis_wren", {31'h0, rwr}, 32'h0);

    d_req(32'h30, 1'b1, 2'd2, 1'b0, 32'h12345678, rd, re, rb, ra, rw, rwr);
    d_req(32'h30, 1'b0, 2'd2, 1'b0, 32'h0, rd, re, rb, ra, rw, rwr);
    chk("lit_lw", rd, 32'h12345678);
    d_req(32'h32, 1'b0, 2'd1, 1'b1, 32'h0, rd, re, rb, ra, rw, rwr);
    chk("lit_lhu", rd, 32'h00001234);

    d_req(32'h400, 1'b1, 2'd3, 1'b0, 32'hFFFFFFFF, rd, re, rb, ra, rw, rwr);
    chk("lit_oor_err", {31'h0, re}, 32'h1);
    chk("lit_oor_strobe", {27'h0, rwr, rb}, 32'h0);

    i_req(32'h12, rd, re);
    chk("lit_fetch_mis_err", {31'h0, re}, 32'h1);
    chk("lit_fetch_mis_data", rd, 32'h0);

    // Both requesters held valid for four grants; the last grant went to fetch.
    @(posedge clock); #1;
    i_addr = 32'h10; d_addr = 32'h20; d_wen = 0; d_size = 2'd2; d_unsigned = 0;
    i_valid = 1; d_valid = 1;
    ord = 4'h0; g = 0; k = 0;
    while (g < 4 && k < 40) begin
      @(negedge clock); k++;
      if (i_ready || d_ready) begin
        ord = {ord[2:0], d_ready};
        g++;
        $display("tie grant %0d -> %s", g, d_ready ? "d" : "i");
      end
    end
    @(posedge clock); #1;
    i_valid = 0; d_valid = 0;
`ifdef MEM_ARBITER_RR_EN
    chk("lit_grant_order", {28'h0, ord}, 32'hA);
`else
    chk("lit_grant_order", {28'h0, ord}, 32'hF);
`endif
    chk("grant_count", g, 32'd4);
    @(negedge clock);

    // Reset in the response cycle drops the pending response.
    @(posedge clock); #1;
    d_addr = 32'h10; d_wen = 0; d_size = 2'd2; d_unsigned = 0; d_valid = 1;
    k = 0;
    do begin @(negedge clock); k++; end while (!d_ready && k < 10);
    chk("rst_test_accept", {31'h0, d_ready}, 32'h1);
    @(posedge clock); #1;
    d_valid = 0; reset = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("no_rsp_after_rst", {30'h0, i_rsp_valid, d_rsp_valid}, 32'h0);
    end
    $display("reset in busy: no response observed after release");
    i_req(32'h10, rd, re);
    chk("lit_fetch_after_rst", rd, 32'hDEADBEEF);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port synchronous word RAM in the shrv32 core. It shares one RAM port between the instruction-fetch unit (word reads) and the load/store unit (byte, half and word accesses). It converts byte addresses and sizes into RAM word address, byte enables and lane-shifted write data. It also aligns and sign- or zero-extends load data returned one cycle later.

## Interface
- RAM_AW, default 8: RAM word-address bits (256 words); bits above are out of range.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  fetch request
- i_ready  out  1  fetch request accepted this cycle
- i_addr  in  32  fetch byte address
- i_rsp_valid  out  1  fetch response, one-cycle pulse
- i_rsp_data  out  32  instruction word
- i_rsp_err  out  1  misaligned or out-of-range fetch
- d_valid  in  1  load/store request
- d_ready  out  1  load/store request accepted this cycle
- d_addr  in  32  byte address
- d_wen  in  1  1 = store
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- d_unsigned  in  1  zero-extend load
- d_wdata  in  32  store data, right-aligned
- d_rsp_valid  out  1  load/store response, one-cycle pulse
- d_rsp_data  out  32  extended load data; 0 for stores
- d_rsp_err  out  1  misaligned, illegal size or out-of-range
- ram_address  out  32  word address {0, addr[RAM_AW+1:2]}
- ram_byteena  out  4  lane enables
- ram_data  out  32  lane-shifted store data
- ram_wren  out  1  write strobe
- ram_q  in  32  registered read data; lanes not enabled read as 0

## Operation
- FSM with two states:
  - IDLE: accepts at most one request. If any valid, go to BUSY.
  - BUSY: drives the response pulse for the granted requester, then returns to IDLE. No grant is made in BUSY.
- i_ready and d_ready are combinational in IDLE. At most one is high. Both are 0 in BUSY.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'hF
- ram_data = d_wdata shifted left by 8·addr[1:0]. Fetch always uses byteena 4'hF with wren 0.
- Error conditions:
  - half with addr[0] = 1
  - word or fetch with addr[1:0] ≠ 0
  - d_size = 3
  - addr[31:RAM_AW+2] ≠ 0
- On error: ram_wren = 0 and ram_byteena = 0 in the accept cycle. The response still occurs in BUSY with err = 1 and data = 0.
- Load response: ram_q is shifted right by 8·registered offset, masked to size, then sign- or zero-extended.
- Store response: data = 0, err = 0. The write is committed in the accept cycle.
- In BUSY and IDLE-with-no-grant: ram_wren = 0, ram_byteena = 0, ram_address = 0, ram_data = 0.

## Timing
- Accept in cycle T (ready & valid) → rsp_valid high only in T+1, with data combinational from ram_q in T+1. Throughput is one access per 2 cycles.
- Reset values: state IDLE; all ready, rsp_valid, err and ram_* outputs 0; all rsp_data 0; round-robin pointer points to fetch (data wins the first tie).
- Reset asserted in BUSY: the pending response is dropped and no pulse is emitted after release.
- A request deasserted before ready has no effect. Requesters hold addr and data stable while valid and not ready.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration. When both requesters are valid in IDLE, grant the one not granted last. A 1-bit last-grant register updates on every accept.
- MEM_ARBITER_RR_EN not defined: fixed priority, data beats fetch. No pointer register exists.
- A single requester is granted immediately in either mode.

## Structure
- Package shrv32_mem_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W)
  - FSM state enum
  - grant-owner enum
  - function computing byteena from size and offset
- Sub-module mem_load_align: combinational. Takes ram_q, offset, size and unsigned flag, and produces the extended load data.

## Test plan
- Fetch 0x10 with the RAM word = 0xDEADBEEF → i_ready in T, i_rsp_valid in T+1 with 0xDEADBEEF, err 0.
- Store byte 0xA5 to 0x23 → ram_address 8, byteena 0b1000, ram_data 0xA5000000, wren 1. Then an lb from 0x23 returns 0xFFFFFFA5; lbu returns 0x000000A5.
- sh 0xBEEF to 0x22, then lh from 0x22 → 0xFFFFBEEF. A lh from 0x21 → d_rsp_err 1, data 0, wren 0.
- Both valid for 4 back-to-back grants:
  - with RR_EN the order is d, i, d, i;
  - without it the order is d, d, d, d.
- d_addr 0x400 (RAM_AW = 8) and d_size 3 → err 1 with no RAM strobe.
- Reset pulsed in BUSY → no rsp_valid follows; next request is served normally.
